// File: rtl/pfd_loop_ctrl.sv
// ADPLL loop controller: syncs PFD flags, measures phase error,
// runs a PI filter onto the DCO control word and reports lock.
module pfd_loop_ctrl #(
  parameter int CODE_W    = 10,
  parameter int ERR_W     = 8,
  parameter int KP_SH     = 2,
  parameter int KI_FRAC   = 4,
  parameter int CODE_INIT = 512,
  parameter int LOCK_TOL  = 1,
  parameter int LOCK_N    = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    flagU,
  input  logic                    flagD,
  output logic [CODE_W-1:0]       dco_code,
  output logic                    code_vld,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    lock
);

  localparam int IW = CODE_W + KI_FRAC + 1;
  localparam int SW = CODE_W + KI_FRAC + 3;
  localparam int LW = $clog2(LOCK_N + 1);

  localparam logic signed [ERR_W-1:0] EMAX =
    ERR_W'(2 ** (ERR_W - 1) - 1);
  localparam logic signed [ERR_W-1:0] TOL = ERR_W'(LOCK_TOL);
  localparam logic signed [IW:0] IMAX =
    (IW + 1)'(2 ** (CODE_W + KI_FRAC) - 1);
  localparam logic signed [SW-1:0] CMAX = SW'(2 ** CODE_W - 1);
  localparam logic signed [SW-1:0] CINIT = SW'(CODE_INIT);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_N);

  typedef enum logic [1:0] {IDLE, MEAS, UPD, WCLR} state_t;

  state_t                  state;
  logic                    u1, su, d1, sd;
  logic signed [ERR_W-1:0] err;
  logic signed [IW-1:0]    integ;
  logic [LW-1:0]           lock_cnt;

  logic signed [ERR_W-1:0] err_base, err_step;
  logic signed [IW:0]      isum;
  logic signed [IW-1:0]    integ_new;
  logic signed [SW-1:0]    sum;
  logic [CODE_W-1:0]       code_new;
  logic                    in_tol;
  logic [LW-1:0]           lcnt_new;
  logic                    quiet;

  assign quiet = !su && !sd;

  always_comb begin
    err_base = (state == IDLE) ? '0 : err;
    err_step = err_base;
    if (su && !sd && err_base != EMAX)
      err_step = err_base + 1'b1;
    else if (sd && !su && err_base != -EMAX)
      err_step = err_base - 1'b1;
  end

  always_comb begin
    isum = (IW + 1)'(integ) + (IW + 1)'(err);
    if (isum > IMAX)
      integ_new = IW'(IMAX);
    else if (isum < -IMAX)
      integ_new = IW'(-IMAX);
    else
      integ_new = IW'(isum);
    sum = CINIT + SW'(integ_new >>> KI_FRAC)
        + (SW'(err) <<< KP_SH);
    if (sum < 0)
      code_new = '0;
    else if (sum > CMAX)
      code_new = CODE_W'(CMAX);
    else
      code_new = CODE_W'(sum);
  end

  // saturated errors are never within tolerance, so they clear lock here
  always_comb begin
    in_tol   = (err <= TOL) && (err >= -TOL);
    lcnt_new = (lock_cnt == LMAX) ? lock_cnt : lock_cnt + 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      u1        <= 1'b0;
      su        <= 1'b0;
      d1        <= 1'b0;
      sd        <= 1'b0;
      err       <= '0;
      integ     <= '0;
      lock_cnt  <= '0;
      dco_code  <= CODE_W'(CODE_INIT);
      code_vld  <= 1'b0;
      phase_err <= '0;
      lock      <= 1'b0;
    end else begin
      u1       <= flagU;
      su       <= u1;
      d1       <= flagD;
      sd       <= d1;
      code_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          err <= '0;
          if (su || sd) begin
            err   <= err_step;
            state <= MEAS;
          end
        end
        MEAS: begin
          if (quiet) begin
            state <= UPD;
          end else begin
            err <= err_step;
            if (err_step == EMAX || err_step == -EMAX)
              state <= UPD;
          end
        end
        UPD: begin
          integ     <= integ_new;
          dco_code  <= code_new;
          phase_err <= err;
          code_vld  <= 1'b1;
          if (in_tol) begin
            lock_cnt <= lcnt_new;
            lock     <= (lcnt_new == LMAX);
          end else begin
            lock_cnt <= '0;
            lock     <= 1'b0;
          end
          state <= quiet ? IDLE : WCLR;
        end
        WCLR: begin
          if (quiet)
            state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pfd_loop_ctrl.sv
// Scoreboard bench for pfd_loop_ctrl: a PI/lock model predicts each
// update; a negedge monitor pops and compares on every code_vld.
module tb_pfd_loop_ctrl;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              flagU = 1'b0;
  logic              flagD = 1'b0;
  logic [9:0]        dco_code;
  logic              code_vld;
  logic signed [7:0] phase_err;
  logic              lock;

  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;

  typedef struct {
    logic [9:0] code;
    logic [7:0] perr;
    logic       lock;
  } exp_t;

  exp_t sb[$];
  int integ_m = 0;
  int lcnt_m = 0;
  logic lock_m = 1'b0;

  pfd_loop_ctrl dut (
    .CLK(CLK),
    .RESET(RESET),
    .flagU(flagU),
    .flagD(flagD),
    .dco_code(dco_code),
    .code_vld(code_vld),
    .phase_err(phase_err),
    .lock(lock)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    integ_m = 0;
    lcnt_m = 0;
    lock_m = 1'b0;
    sb.delete();
  endtask

  task automatic model_push(input int e);
    int sum;
    exp_t x;
    integ_m = integ_m + e;
    if (integ_m > 16383) integ_m = 16383;
    if (integ_m < -16383) integ_m = -16383;
    sum = 512 + (integ_m >>> 4) + e * 4;
    if (sum < 0) sum = 0;
    if (sum > 1023) sum = 1023;
    if (e <= 1 && e >= -1) begin
      if (lcnt_m < 8) lcnt_m++;
      lock_m = (lcnt_m == 8);
    end else begin
      lcnt_m = 0;
      lock_m = 1'b0;
    end
    x.code = 10'(sum);
    x.perr = 8'(e);
    x.lock = lock_m;
    sb.push_back(x);
  endtask

  always @(negedge CLK) begin
    if (!RESET && code_vld) begin
      exp_t x;
      vld_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_vld code=%0d required=none",
                 dco_code);
      end else begin
        x = sb.pop_front();
        if (dco_code !== x.code) begin
          failures++;
          $display("FAIL dco_code got=%0d required=%0d",
                   dco_code, x.code);
        end
        checks++;
        if (phase_err !== x.perr) begin
          failures++;
          $display("FAIL phase_err got=%0d required=%0d",
                   phase_err, $signed(x.perr));
        end
        checks++;
        if (lock !== x.lock) begin
          failures++;
          $display("FAIL lock got=%0b required=%0b", lock, x.lock);
        end
      end
    end
  end

  task automatic run_event(input int lead, input bit up,
                           input int both);
    int e;
    e = up ? lead : -lead;
    if (e > 127) e = 127;
    if (e < -127) e = -127;
    model_push(e);
    repeat (lead) begin
      @(negedge CLK);
      flagU = up;
      flagD = !up;
    end
    repeat (both) begin
      @(negedge CLK);
      flagU = 1'b1;
      flagD = 1'b1;
    end
    @(negedge CLK);
    flagU = 1'b0;
    flagD = 1'b0;
    repeat (10) @(negedge CLK);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (dco_code !== 10'd512 || lock !== 1'b0 ||
        code_vld !== 1'b0 || phase_err !== 8'sd0) begin
      failures++;
      $display("FAIL %s got code=%0d lock=%0b vld=%0b err=%0d required=512/0/0/0",
               tag, dco_code, lock, code_vld, phase_err);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_vals("reset_asserted");
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_reset_vals("reset_hold");
    end
  endtask

  task automatic test_up_lead();
    int v0;
    v0 = vld_cnt;
    run_event(4, 1'b1, 1);
    checks++;
    if (vld_cnt - v0 !== 1) begin
      failures++;
      $display("FAIL up_lead_pulses got=%0d required=1", vld_cnt - v0);
    end
  endtask

  task automatic test_down_lead();
    run_event(4, 1'b0, 1);
  endtask

  task automatic test_saturate();
    int v0;
    v0 = vld_cnt;
    model_push(127);
    @(negedge CLK);
    flagU = 1'b1;
    repeat (300) @(negedge CLK);
    checks++;
    if (vld_cnt - v0 !== 1) begin
      failures++;
      $display("FAIL sat_one_update got=%0d required=1", vld_cnt - v0);
    end
    flagU = 1'b0;
    repeat (12) @(negedge CLK);
    checks++;
    if (vld_cnt - v0 !== 1) begin
      failures++;
      $display("FAIL sat_after_fall got=%0d required=1", vld_cnt - v0);
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 8; i++)
      run_event(0, 1'b1, 3);
    checks++;
    if (lock !== 1'b1) begin
      failures++;
      $display("FAIL lock_level got=%0b required=1", lock);
    end
    run_event(1, 1'b0, 2);
    run_event(3, 1'b1, 1);
    checks++;
    if (lock !== 1'b0) begin
      failures++;
      $display("FAIL unlock_level got=%0b required=0", lock);
    end
  endtask

  task automatic test_reset_mid_meas();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_before_reset got=%0d required=0", sb.size());
    end
    @(negedge CLK);
    flagU = 1'b1;
    repeat (6) @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_reset_vals("reset_mid_meas");
    model_reset();
    @(negedge CLK);
    flagU = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_vals("reset_released");
    run_event(3, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_event(2, 1'b1, 0);
    run_event(5, 1'b0, 2);
    run_event(0, 1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_up_lead();
    test_down_lead();
    test_saturate();
    test_lock();
    test_reset_mid_meas();
    test_back_to_back();
    repeat (5) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_updates got=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
